// File: rtl/lcd_pkg.sv
// Shared types, init ROM contents and timing helpers for the HD44780 write controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT,
    ST_INIT_LOAD,
    ST_SETUP,
    ST_EN_HI,
    ST_EN_LO,
    ST_WAIT,
    ST_IDLE
  } lcd_state_t;

  // Post-write wait selector; WAIT_AUTO picks clear/home or normal from the byte itself.
  typedef enum logic [1:0] {
    WAIT_AUTO,
    WAIT_4100US,
    WAIT_100US
  } init_wait_t;

  typedef struct packed {
    logic       nibble_only;
    init_wait_t wait_sel;
    logic [7:0] data;
  } init_entry_t;

  localparam int INIT_LEN_8  = 8;
  localparam int INIT_LEN_4  = 9;
  localparam int T_INIT1_US  = 4100;
  localparam int T_INIT2_US  = 100;

  // Ceiling of clk_hz * t_ns / 1e9.
  function automatic longint cycles_ns(input longint clk_hz, input longint t_ns);
    return (clk_hz * t_ns + 999999999) / 1000000000;
  endfunction

  // Ceiling of clk_hz * t_us / 1e6.
  function automatic longint cycles_us(input longint clk_hz, input longint t_us);
    return (clk_hz * t_us + 999999) / 1000000;
  endfunction

  function automatic int at_least_one(input longint v);
    return (v < 1) ? 1 : int'(v);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // 8-bit bus init: three wake-up writes, function set, display off, clear, entry mode, display on.
  function automatic init_entry_t init_rom_8(input logic [3:0] idx);
    init_entry_t e;
    case (idx)
      4'd0:    e = '{1'b0, WAIT_4100US, 8'h30};
      4'd1:    e = '{1'b0, WAIT_100US,  8'h30};
      4'd2:    e = '{1'b0, WAIT_AUTO,   8'h30};
      4'd3:    e = '{1'b0, WAIT_AUTO,   8'h38};
      4'd4:    e = '{1'b0, WAIT_AUTO,   8'h08};
      4'd5:    e = '{1'b0, WAIT_AUTO,   8'h01};
      4'd6:    e = '{1'b0, WAIT_AUTO,   8'h06};
      default: e = '{1'b0, WAIT_AUTO,   8'h0C};
    endcase
    return e;
  endfunction

  // 4-bit bus init: single high nibbles 3,3,3,2 switch the panel to 4-bit, then full bytes.
  function automatic init_entry_t init_rom_4(input logic [3:0] idx);
    init_entry_t e;
    case (idx)
      4'd0:    e = '{1'b1, WAIT_4100US, 8'h30};
      4'd1:    e = '{1'b1, WAIT_100US,  8'h30};
      4'd2:    e = '{1'b1, WAIT_AUTO,   8'h30};
      4'd3:    e = '{1'b1, WAIT_AUTO,   8'h20};
      4'd4:    e = '{1'b0, WAIT_AUTO,   8'h28};
      4'd5:    e = '{1'b0, WAIT_AUTO,   8'h08};
      4'd6:    e = '{1'b0, WAIT_AUTO,   8'h01};
      4'd7:    e = '{1'b0, WAIT_AUTO,   8'h06};
      default: e = '{1'b0, WAIT_AUTO,   8'h0C};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lcd_hd44780_ctrl_fifo.sv
// Small synchronous FIFO holding {rs, data} writes; flags are registered, head is read combinationally.
module lcd_cmd_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lcd_cmd_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]      count_reg, count_next;
  logic             full_reg, empty_reg;
  logic             push, pop;

  // A write on full is dropped; a pop on full only frees the slot for the next cycle.
  assign push = wr_en && !full_reg;
  assign pop  = rd_en && !empty_reg;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + (AW + 1)'(1);
    else if (!push && pop)
      count_next = count_reg - (AW + 1)'(1);
  end

  // Storage array, no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers, occupancy and registered full/empty flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      full_reg  <= (count_next == (AW + 1)'(DEPTH));
      empty_reg <= (count_next == '0);
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = full_reg;
  assign empty   = empty_reg;

endmodule

// File: rtl/lcd_hd44780_ctrl.sv
// HD44780 write controller: power-on init from ROM, then drains the command FIFO to the panel pins.
module lcd_hd44780_ctrl
  import lcd_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BUS_W      = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int T_EN_NS    = 500,
  parameter int T_SU_NS    = 60,
  parameter int T_CMD_US   = 50,
  parameter int T_CLR_US   = 1640,
  parameter int T_PWR_MS   = 15
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rs,
  input  logic [7:0]       cmd_data,
  output logic             init_done,
  output logic             busy,
  output logic [BUS_W-1:0] lcd_display_data,
  output logic             lcd_enable,
  output logic             lcd_rs,
  output logic             lcd_rw
);

  if (BUS_W != 8 && BUS_W != 4) begin : g_bad_bus_w
    $error("lcd_hd44780_ctrl: BUS_W must be 8 or 4");
  end

  localparam int EN_CYC    = at_least_one(cycles_ns(CLK_HZ, T_EN_NS));
  localparam int SU_CYC    = at_least_one(cycles_ns(CLK_HZ, T_SU_NS));
  localparam int CMD_CYC   = at_least_one(cycles_us(CLK_HZ, T_CMD_US));
  localparam int CLR_CYC   = at_least_one(cycles_us(CLK_HZ, T_CLR_US));
  localparam int PWR_CYC   = at_least_one(cycles_us(CLK_HZ, longint'(T_PWR_MS) * 1000));
  localparam int INIT1_CYC = at_least_one(cycles_us(CLK_HZ, T_INIT1_US));
  localparam int INIT2_CYC = at_least_one(cycles_us(CLK_HZ, T_INIT2_US));
  localparam int MAX_CYC   = max_int(max_int(max_int(PWR_CYC, INIT1_CYC), max_int(CLR_CYC, CMD_CYC)),
                                     max_int(max_int(EN_CYC, SU_CYC), INIT2_CYC));
  localparam int CNT_W     = $clog2(MAX_CYC) + 1;
  localparam int INIT_LEN  = (BUS_W == 8) ? INIT_LEN_8 : INIT_LEN_4;

  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(PWR_CYC - 1);
  localparam logic [CNT_W-1:0] SU_LAST  = CNT_W'(SU_CYC - 1);
  localparam logic [CNT_W-1:0] EN_LAST  = CNT_W'(EN_CYC - 1);

  logic             fifo_full, fifo_empty, fifo_pop;
  logic [8:0]       fifo_head;
  lcd_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg, wait_last;
  logic [3:0]       init_idx_reg;
  logic             in_init_reg, low_pending_reg, init_done_reg;
  logic             enable_reg, rs_reg;
  logic [7:0]       byte_reg;
  init_wait_t       wsel_reg;
  logic [BUS_W-1:0] data_reg;
  init_entry_t      rom_entry;

  lcd_cmd_fifo #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst     (reset_reset),
    .wr_en   (cmd_valid),
    .wr_data ({cmd_rs, cmd_data}),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign fifo_pop = (state_reg == ST_IDLE) && !fifo_empty;

  // Current init ROM entry for the configured bus width.
  always_comb begin
    if (BUS_W == 8)
      rom_entry = init_rom_8(init_idx_reg);
    else
      rom_entry = init_rom_4(init_idx_reg);
  end

  // Post-write wait length: forced for the wake-up writes, else clear/home vs normal.
  always_comb begin
    case (wsel_reg)
      WAIT_4100US: wait_last = CNT_W'(INIT1_CYC - 1);
      WAIT_100US:  wait_last = CNT_W'(INIT2_CYC - 1);
      default: begin
        if (!rs_reg && (byte_reg inside {8'h01, 8'h02, 8'h03}))
          wait_last = CNT_W'(CLR_CYC - 1);
        else
          wait_last = CNT_W'(CMD_CYC - 1);
      end
    endcase
  end

  // Sequencer: every state lasts its full count; pin outputs change only on state transitions.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg       <= ST_PWR_WAIT;
      cnt_reg         <= '0;
      init_idx_reg    <= '0;
      in_init_reg     <= 1'b1;
      low_pending_reg <= 1'b0;
      init_done_reg   <= 1'b0;
      enable_reg      <= 1'b0;
      rs_reg          <= 1'b0;
      byte_reg        <= '0;
      wsel_reg        <= WAIT_AUTO;
      data_reg        <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
      case (state_reg)
        ST_PWR_WAIT: begin
          if (cnt_reg == PWR_LAST) begin
            state_reg <= ST_INIT_LOAD;
            cnt_reg   <= '0;
          end
        end
        ST_INIT_LOAD: begin
          rs_reg          <= 1'b0;
          byte_reg        <= rom_entry.data;
          wsel_reg        <= rom_entry.wait_sel;
          low_pending_reg <= (BUS_W == 4) && !rom_entry.nibble_only;
          data_reg        <= rom_entry.data[7 -: BUS_W];
          state_reg       <= ST_SETUP;
          cnt_reg         <= '0;
        end
        ST_SETUP: begin
          if (cnt_reg == SU_LAST) begin
            enable_reg <= 1'b1;
            state_reg  <= ST_EN_HI;
            cnt_reg    <= '0;
          end
        end
        ST_EN_HI: begin
          if (cnt_reg == EN_LAST) begin
            enable_reg <= 1'b0;
            state_reg  <= ST_EN_LO;
            cnt_reg    <= '0;
          end
        end
        ST_EN_LO: begin
          if (cnt_reg == EN_LAST) begin
            cnt_reg <= '0;
            if (low_pending_reg) begin
              low_pending_reg <= 1'b0;
              data_reg        <= byte_reg[BUS_W-1:0];
              state_reg       <= ST_SETUP;
            end else begin
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (cnt_reg == wait_last) begin
            cnt_reg <= '0;
            if (in_init_reg) begin
              if (init_idx_reg == 4'(INIT_LEN - 1)) begin
                in_init_reg   <= 1'b0;
                init_done_reg <= 1'b1;
                state_reg     <= ST_IDLE;
              end else begin
                init_idx_reg <= init_idx_reg + 4'd1;
                state_reg    <= ST_INIT_LOAD;
              end
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_IDLE: begin
          cnt_reg <= '0;
          if (!fifo_empty) begin
            rs_reg          <= fifo_head[8];
            byte_reg        <= fifo_head[7:0];
            wsel_reg        <= WAIT_AUTO;
            low_pending_reg <= (BUS_W == 4);
            data_reg        <= fifo_head[7 -: BUS_W];
            state_reg       <= ST_SETUP;
          end
        end
        default: begin
          state_reg <= ST_PWR_WAIT;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign cmd_ready        = !fifo_full;
  assign busy             = !((state_reg == ST_IDLE) && fifo_empty);
  assign init_done        = init_done_reg;
  assign lcd_display_data = data_reg;
  assign lcd_enable       = enable_reg;
  assign lcd_rs           = rs_reg;
  assign lcd_rw           = 1'b0;

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// Scoreboard bench: an 8-bit/depth-4 and a 4-bit/depth-8 controller at CLK_HZ = 1 MHz (1 cycle = 1 us).
module tb_lcd_hd44780_ctrl;

  // Hand-derived timing at 1 MHz: E pulse 1, setup 1, waits in microseconds = cycles.
  localparam int EN    = 1;
  localparam int SU    = 1;
  localparam int PWR   = 15000;
  localparam int CMD   = 50;
  localparam int CLR   = 1640;
  localparam int FIRST = PWR + 1 + SU;   // PWR_WAIT, INIT_LOAD, SETUP, then E rises
  localparam int NIB   = 2 * EN + SU;    // rise-to-rise between the two nibbles of a byte

  typedef struct packed {
    logic       rs;
    logic [7:0] d;
    int         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  int         cyc = 0;
  int         rel_cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  logic       v8, rs8, rdy8, done8, busy8, e8, lrs8, rw8;
  logic [7:0] d8, dat8;
  logic       v4, rs4, rdy4, done4, busy4, e4, lrs4, rw4;
  logic [7:0] d4;
  logic [3:0] dat4;

  exp_t q8[$];
  exp_t q4[$];
  logic prev_e[2];
  int   last_rise[2];
  exp_t cur[2];
  logic cur_ok[2];
  int   t_sum[2];
  int   exp_done[2];

  logic       p_rs [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [7:0] p_d  [6] = '{8'h41, 8'h42, 8'h01, 8'h43, 8'h44, 8'h45};

  lcd_hd44780_ctrl #(.CLK_HZ(1000000), .BUS_W(8), .FIFO_DEPTH(4)) u8 (
    .clk_clk(clk), .reset_reset(rst), .cmd_valid(v8), .cmd_ready(rdy8), .cmd_rs(rs8),
    .cmd_data(d8), .init_done(done8), .busy(busy8), .lcd_display_data(dat8),
    .lcd_enable(e8), .lcd_rs(lrs8), .lcd_rw(rw8));

  lcd_hd44780_ctrl #(.CLK_HZ(1000000), .BUS_W(4), .FIFO_DEPTH(8)) u4 (
    .clk_clk(clk), .reset_reset(rst), .cmd_valid(v4), .cmd_ready(rdy4), .cmd_rs(rs4),
    .cmd_data(d4), .init_done(done4), .busy(busy4), .lcd_display_data(dat4),
    .lcd_enable(e4), .lcd_rs(lrs4), .lcd_rw(rw4));

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc - rel_cyc);
  endtask

  function automatic int g(input int w);
    return 2 * EN + w + 1 + SU;
  endfunction

  task automatic px(input int k, input logic rs, input logic [7:0] d, input int gap);
    exp_t x;
    x.rs = rs; x.d = d; x.gap = gap;
    if (k == 0) q8.push_back(x); else q4.push_back(x);
    t_sum[k] += gap;
  endtask

  task automatic load_init();
    t_sum[0] = 0; t_sum[1] = 0;
    px(0, 0, 8'h30, FIRST); px(0, 0, 8'h30, g(4100)); px(0, 0, 8'h30, g(100));
    px(0, 0, 8'h38, g(CMD)); px(0, 0, 8'h08, g(CMD)); px(0, 0, 8'h01, g(CMD));
    px(0, 0, 8'h06, g(CLR)); px(0, 0, 8'h0C, g(CMD));
    px(1, 0, 8'h3, FIRST); px(1, 0, 8'h3, g(4100)); px(1, 0, 8'h3, g(100)); px(1, 0, 8'h2, g(CMD));
    px(1, 0, 8'h2, g(CMD)); px(1, 0, 8'h8, NIB); px(1, 0, 8'h0, g(CMD)); px(1, 0, 8'h8, NIB);
    px(1, 0, 8'h0, g(CMD)); px(1, 0, 8'h1, NIB); px(1, 0, 8'h0, g(CLR)); px(1, 0, 8'h6, NIB);
    px(1, 0, 8'h0, g(CMD)); px(1, 0, 8'hC, NIB);
    exp_done[0] = t_sum[0] + 2 * EN + CMD;
    exp_done[1] = t_sum[1] + 2 * EN + CMD;
  endtask

  // Compares each E rise against the head of that instance's expected queue.
  task automatic mon_step(input int k, input logic e, input logic rs, input logic [7:0] d);
    exp_t x;
    if (e && !prev_e[k]) begin
      $display("pulse u%0d rs=%0b data=%02h cycle=%0d", (k == 0) ? 8 : 4, rs, d, cyc - rel_cyc);
      if ((k == 0 && q8.size() == 0) || (k == 1 && q4.size() == 0)) begin
        n_chk++;
        $display("FAIL unexpected_pulse[%0d]: got rs=%0b data=%02h, expected no pulse", k, rs, d);
        cur_ok[k] = 1'b0;
      end else begin
        if (k == 0) x = q8.pop_front(); else x = q4.pop_front();
        chk($sformatf("rs_at_rise[%0d]", k), 32'(rs), 32'(x.rs));
        chk($sformatf("data_at_rise[%0d]", k), 32'(d), 32'(x.d));
        if (x.gap > 0) chk($sformatf("rise_gap[%0d]", k), cyc - last_rise[k], x.gap);
        cur[k] = x; cur_ok[k] = 1'b1;
      end
      last_rise[k] = cyc;
    end else if (!e && prev_e[k] && cur_ok[k]) begin
      chk($sformatf("data_at_fall[%0d]", k), 32'(d), 32'(cur[k].d));
      chk($sformatf("rs_at_fall[%0d]", k), 32'(rs), 32'(cur[k].rs));
      cur_ok[k] = 1'b0;
    end
    prev_e[k] = e;
  endtask

  // Monitor process, decoupled from stimulus.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        prev_e[k] = 1'b0; last_rise[k] = cyc; cur_ok[k] = 1'b0;
      end
    end else begin
      mon_step(0, e8, lrs8, dat8);
      mon_step(1, e4, lrs4, {4'h0, dat4});
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_enable8"}, 32'(e8), 0);    chk({tag, "_enable4"}, 32'(e4), 0);
    chk({tag, "_busy8"}, 32'(busy8), 1);   chk({tag, "_busy4"}, 32'(busy4), 1);
    chk({tag, "_ready8"}, 32'(rdy8), 1);   chk({tag, "_ready4"}, 32'(rdy4), 1);
    chk({tag, "_done8"}, 32'(done8), 0);   chk({tag, "_done4"}, 32'(done4), 0);
    chk({tag, "_rs8"}, 32'(lrs8), 0);      chk({tag, "_data8"}, 32'(dat8), 0);
    chk({tag, "_data4"}, 32'(dat4), 0);    chk({tag, "_rw"}, 32'({rw8, rw4}), 0);
  endtask

  task automatic wait_init_done();
    int got8 = -1;
    int got4 = -1;
    for (int i = 0; i < 25000 && (got8 < 0 || got4 < 0); i++) begin
      @(negedge clk);
      if (done8 && got8 < 0) got8 = cyc - rel_cyc;
      if (done4 && got4 < 0) got4 = cyc - rel_cyc;
    end
    chk("init_done_cycle8", got8, exp_done[0]);
    chk("init_done_cycle4", got4, exp_done[1]);
  endtask

  task automatic wait_drained();
    for (int i = 0; i < 5000 && (q8.size() + q4.size()) != 0; i++) @(negedge clk);
    chk("queues_drained", q8.size() + q4.size(), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    rel_cyc = cyc;
  endtask

  initial begin
    int t0;
    rst = 1'b1; v8 = 0; rs8 = 0; d8 = 0; v4 = 0; rs4 = 0; d4 = 0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");

    load_init();
    px(0, 1, 8'h41, g(CMD)); px(0, 1, 8'h42, g(CMD)); px(0, 0, 8'h01, g(CMD)); px(0, 1, 8'h43, g(CLR));
    px(1, 1, 8'h4, g(CMD)); px(1, 1, 8'h1, NIB); px(1, 0, 8'h0, g(CMD)); px(1, 0, 8'h1, NIB);
    release_reset();

    // Six back-to-back writes into the depth-4 FIFO during the power-up wait.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("ready8_before_push%0d", i), 32'(rdy8), (i < 4) ? 1 : 0);
      v8 = 1'b1; rs8 = p_rs[i]; d8 = p_d[i];
      if (i < 2) begin v4 = 1'b1; rs4 = p_rs[i * 2]; d4 = p_d[i * 2]; end
      else v4 = 1'b0;
    end
    @(negedge clk);
    v8 = 1'b0; v4 = 1'b0;
    chk("ready8_full_after_pushes", 32'(rdy8), 0);
    chk("busy8_during_init", 32'(busy8), 1);

    wait_init_done();
    wait_drained();

    // Last write was rs=1 0x43: busy drops after EN_HI, EN_LO and the normal wait.
    t0 = -1;
    for (int i = 0; i < 300 && t0 < 0; i++) begin
      @(negedge clk);
      if (!busy8) t0 = cyc - last_rise[0];
    end
    chk("busy8_fall_after_rise", t0, 2 * EN + CMD);
    for (int i = 0; i < 2500 && busy4; i++) @(negedge clk);
    chk("busy4_idle", 32'(busy4), 0);
    chk("ready8_after_drain", 32'(rdy8), 1);

    // Queue two writes, then hit reset while the first one has E high.
    px(0, 1, 8'h55, 0);
    @(negedge clk); v8 = 1'b1; rs8 = 1'b1; d8 = 8'h55;
    @(negedge clk); d8 = 8'h56;
    @(negedge clk); v8 = 1'b0;
    for (int i = 0; i < 20 && !e8; i++) @(negedge clk);
    chk("enable8_high_before_reset", 32'(e8), 1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midwrite_reset");
    chk("queue8_after_reset", q8.size(), 0);

    load_init();
    repeat (3) @(negedge clk);
    release_reset();
    wait_init_done();
    wait_drained();
    repeat (200) @(negedge clk);
    chk("busy8_idle_after_replay", 32'(busy8), 0);
    chk("busy4_idle_after_replay", 32'(busy4), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got no finish, expected finish within 90000 cycles");
    $display("%0d/%0d checks passed", n_pass, n_chk + 1);
    $fatal(1, "watchdog");
  end

endmodule
